// File: rtl/divider_sweep_controller_if.sv
// Host-side handshake, sweep configuration and measurement results of the divider sweep controller.
// The divider feedback clock travels with them.
interface divider_sweep_controller_if #(
   parameter int STEP_W  = 8,
   parameter int DWELL_W = 16,
   parameter int MEAS_W  = 16
);
   logic               start;
   logic               abort;
   logic [STEP_W-1:0]  cfg_steps;
   logic [DWELL_W-1:0] cfg_dwell;
   logic               cfg_continuous;
   logic               div_clock;
   logic               step_divisor;
   logic               busy;
   logic               done;
   logic [STEP_W-1:0]  step_index;
   logic [MEAS_W-1:0]  meas_count;
   logic               meas_valid;

   modport master (
      output start, abort, cfg_steps, cfg_dwell, cfg_continuous, div_clock,
      input  step_divisor, busy, done, step_index, meas_count, meas_valid
   );

   modport slave (
      input  start, abort, cfg_steps, cfg_dwell, cfg_continuous, div_clock,
      output step_divisor, busy, done, step_index, meas_count, meas_valid
   );
endinterface

// File: rtl/divider_sweep_controller.sv
// Steps a frequency divider through N divisor settings, dwelling D cycles on each.
// It counts divider output edges during every dwell and reports the count per step.
module divider_sweep_controller #(
   parameter int STEP_W      = 8,
   parameter int DWELL_W     = 16,
   parameter int MEAS_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                     clock_in,
   input  logic                     nreset,
   divider_sweep_controller_if.slave bus
);
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DWELL = 2'd1,
      ST_STEP  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [STEP_W-1:0]  STEP_ONE  = STEP_W'(1);
   localparam logic [STEP_W-1:0]  STEP_ZERO = {STEP_W{1'b0}};
   localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);
   localparam logic [DWELL_W-1:0] DWELL_ZERO = {DWELL_W{1'b0}};
   localparam logic [MEAS_W-1:0]  MEAS_ONE  = MEAS_W'(1);
   localparam logic [MEAS_W-1:0]  MEAS_ZERO = {MEAS_W{1'b0}};
   localparam logic [MEAS_W-1:0]  MEAS_MAX  = {MEAS_W{1'b1}};

   state_t             state_r, state_nx_s;
   logic [SYNC_STAGES-1:0] sync_r;
   logic               edge_dly_r;
   logic               edge_s;
   logic               start_ok_s;
   logic [STEP_W-1:0]  steps_r, step_index_r, index_nx_s;
   logic [DWELL_W-1:0] dwell_len_r, dwell_cnt_r, dwell_nx_s;
   logic [MEAS_W-1:0]  edge_cnt_r, edge_nx_s, meas_count_r;
   logic               continuous_r;
   logic               step_divisor_r, busy_r, done_r, meas_valid_r;

   assign edge_s     = sync_r[SYNC_STAGES-1] & ~edge_dly_r;
   assign start_ok_s = bus.start & ~bus.abort & (bus.cfg_steps != STEP_ZERO)
                       & (bus.cfg_dwell != DWELL_ZERO);

   // Synchronise the divider clock and keep one extra stage for rising-edge detection.
   always_ff @(posedge clock_in or negedge nreset) begin
      if (!nreset) begin
         sync_r     <= {SYNC_STAGES{1'b0}};
         edge_dly_r <= 1'b0;
      end else begin
         sync_r     <= {sync_r[SYNC_STAGES-2:0], bus.div_clock};
         edge_dly_r <= sync_r[SYNC_STAGES-1];
      end
   end

   // Next-state and counter update logic; abort overrides everything outside IDLE.
   always_comb begin
      state_nx_s = state_r;
      dwell_nx_s = dwell_cnt_r;
      edge_nx_s  = edge_cnt_r;
      index_nx_s = step_index_r;
      case (state_r)
         ST_IDLE: begin
            if (start_ok_s) begin
               state_nx_s = ST_DWELL;
               dwell_nx_s = DWELL_ZERO;
               edge_nx_s  = MEAS_ZERO;
               index_nx_s = STEP_ZERO;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_DWELL: begin
            if (edge_s && (edge_cnt_r != MEAS_MAX)) begin
               edge_nx_s = edge_cnt_r + MEAS_ONE;
            end else begin
               edge_nx_s = edge_cnt_r;
            end
            if (bus.abort) begin
               state_nx_s = ST_IDLE;
            end else if (dwell_cnt_r == (dwell_len_r - DWELL_ONE)) begin
               state_nx_s = ST_STEP;
            end else begin
               dwell_nx_s = dwell_cnt_r + DWELL_ONE;
            end
         end
         ST_STEP: begin
            // Edges seen during the step cycle belong to no dwell and are dropped.
            dwell_nx_s = DWELL_ZERO;
            edge_nx_s  = MEAS_ZERO;
            if (bus.abort) begin
               state_nx_s = ST_IDLE;
            end else if (step_index_r != (steps_r - STEP_ONE)) begin
               state_nx_s = ST_DWELL;
               index_nx_s = step_index_r + STEP_ONE;
            end else if (continuous_r) begin
               state_nx_s = ST_DWELL;
               index_nx_s = STEP_ZERO;
            end else begin
               state_nx_s = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nx_s = ST_IDLE;
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // State, counters and the configuration captured at a valid start.
   always_ff @(posedge clock_in or negedge nreset) begin
      if (!nreset) begin
         state_r      <= ST_IDLE;
         dwell_cnt_r  <= DWELL_ZERO;
         edge_cnt_r   <= MEAS_ZERO;
         step_index_r <= STEP_ZERO;
         steps_r      <= STEP_ZERO;
         dwell_len_r  <= DWELL_ZERO;
         continuous_r <= 1'b0;
      end else begin
         state_r      <= state_nx_s;
         dwell_cnt_r  <= dwell_nx_s;
         edge_cnt_r   <= edge_nx_s;
         step_index_r <= index_nx_s;
         if ((state_r == ST_IDLE) && start_ok_s) begin
            steps_r      <= bus.cfg_steps;
            dwell_len_r  <= bus.cfg_dwell;
            continuous_r <= bus.cfg_continuous;
         end
      end
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clock_in or negedge nreset) begin
      if (!nreset) begin
         step_divisor_r <= 1'b0;
         meas_valid_r   <= 1'b0;
         busy_r         <= 1'b0;
         done_r         <= 1'b0;
         meas_count_r   <= MEAS_ZERO;
      end else begin
         step_divisor_r <= (state_nx_s == ST_STEP);
         meas_valid_r   <= (state_nx_s == ST_STEP);
         busy_r         <= (state_nx_s == ST_DWELL) || (state_nx_s == ST_STEP);
         done_r         <= (state_nx_s == ST_DONE);
         if (state_nx_s == ST_STEP) begin
            meas_count_r <= edge_nx_s;
         end
      end
   end

   assign bus.step_divisor = step_divisor_r;
   assign bus.meas_valid   = meas_valid_r;
   assign bus.busy         = busy_r;
   assign bus.done         = done_r;
   assign bus.step_index   = step_index_r;
   assign bus.meas_count   = meas_count_r;
endmodule

// File: tb/tb_divider_sweep_controller.sv
// Randomised self-checking bench for divider_sweep_controller.
// Expected sweep timing and edge counts come from closed-form cycle arithmetic.
module tb_divider_sweep_controller;
   localparam int SYNC = 2;

   logic clock_in = 1'b0;
   logic nreset;
   int   cyc = 0;
   int   div_period = 0;
   int   div_phase = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   logic [15:0] exp_meas = 16'd0;

   divider_sweep_controller_if #(.STEP_W(8), .DWELL_W(16), .MEAS_W(16)) bus ();
   divider_sweep_controller_if #(.STEP_W(8), .DWELL_W(16), .MEAS_W(4))  sat_bus ();

   divider_sweep_controller #(.STEP_W(8), .DWELL_W(16), .MEAS_W(16), .SYNC_STAGES(SYNC)) u_dut (
      .clock_in (clock_in),
      .nreset   (nreset),
      .bus      (bus.slave)
   );

   divider_sweep_controller #(.STEP_W(8), .DWELL_W(16), .MEAS_W(4), .SYNC_STAGES(SYNC)) u_sat (
      .clock_in (clock_in),
      .nreset   (nreset),
      .bus      (sat_bus.slave)
   );

   always #5 clock_in = ~clock_in;
   always @(posedge clock_in) cyc <= cyc + 1;

   // Divider output level during bench cycle q.
   function automatic bit div_at(input int q, input int per, input int ph);
      if (per == 0) return 1'b0;
      return ((q + ph) % per) < (per / 2);
   endfunction

   assign bus.div_clock     = div_at(cyc, div_period, div_phase);
   assign sat_bus.div_clock = div_at(cyc, div_period, div_phase);

   // Rising edges visible to the controller during cycles q0..q1 (synchroniser latency SYNC).
   function automatic int rises(input int q0, input int q1);
      int c = 0;
      for (int q = q0; q <= q1; q++)
         if (div_at(q - SYNC, div_period, div_phase) && !div_at(q - SYNC - 1, div_period, div_phase))
            c++;
      return c;
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic idle(input int k);
      repeat (k) @(negedge clock_in);
   endtask

   // One sweep from start to end, with optional abort and ignored re-start.
   task automatic run_sweep(input int ns, input int d, input bit cont, input int abort_at, input int restart_at);
      int len = d + 1;
      int end_n = (abort_at > 0) ? abort_at + 4 : ns * len + 4;
      int base, m, idx_e, cnt;
      bit active, busy_e, step_e, done_e;
      @(negedge clock_in);
      bus.cfg_steps      = 8'(ns);
      bus.cfg_dwell      = 16'(d);
      bus.cfg_continuous = cont;
      bus.start          = 1'b1;
      base = cyc;
      for (int n = 1; n <= end_n; n++) begin
         @(negedge clock_in);
         if (n == 1) begin
            bus.start          = 1'b0;
            bus.cfg_steps      = 8'($urandom_range(1, 255));
            bus.cfg_dwell      = 16'($urandom_range(1, 500));
            bus.cfg_continuous = ~cont;
         end
         if (n == abort_at + 1) bus.abort = 1'b0;
         if (n == restart_at + 1) bus.start = 1'b0;
         active = (abort_at == 0) || (n <= abort_at);
         busy_e = active && (cont || (n <= ns * len));
         step_e = busy_e && (n % len == 0);
         done_e = active && !cont && (n == ns * len + 1);
         m = active ? n : abort_at;
         if (!cont && m > ns * len) m = ns * len;
         idx_e = ((m - 1) / len) % ns;
         if (step_e) begin
            cnt = rises(base + n - d, base + n - 1);
            exp_meas = (cnt > 65535) ? 16'hFFFF : 16'(cnt);
         end
         check_eq($sformatf("step_divisor@%0d", n), bus.step_divisor, step_e);
         check_eq($sformatf("meas_valid@%0d", n), bus.meas_valid, step_e);
         check_eq($sformatf("busy@%0d", n), bus.busy, busy_e);
         check_eq($sformatf("done@%0d", n), bus.done, done_e);
         check_eq($sformatf("step_index@%0d", n), bus.step_index, idx_e);
         check_eq($sformatf("meas_count@%0d", n), bus.meas_count, exp_meas);
         if (n == abort_at) bus.abort = 1'b1;
         if (restart_at > 0 && n == restart_at) bus.start = 1'b1;
      end
   endtask

   // A start that must be ignored: zero config or accompanied by abort.
   task automatic start_ignored(input int ns, input int d, input bit with_abort);
      @(negedge clock_in);
      bus.cfg_steps = 8'(ns);
      bus.cfg_dwell = 16'(d);
      bus.abort     = with_abort;
      bus.start     = 1'b1;
      @(negedge clock_in);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      for (int n = 0; n < 12; n++) begin
         check_eq("ign_busy", bus.busy, 1'b0);
         check_eq("ign_step", bus.step_divisor | bus.meas_valid | bus.done, 1'b0);
         @(negedge clock_in);
      end
   endtask

   int periods[6] = '{0, 2, 3, 4, 5, 7};

   initial begin
      int base, hit, ns, d, ab, rs, cnt;
      bit cont;
      nreset = 1'b0;
      bus.start = 1'b0; bus.abort = 1'b0; bus.cfg_steps = 8'd0; bus.cfg_dwell = 16'd0; bus.cfg_continuous = 1'b0;
      sat_bus.start = 1'b0; sat_bus.abort = 1'b0; sat_bus.cfg_steps = 8'd0; sat_bus.cfg_dwell = 16'd0;
      sat_bus.cfg_continuous = 1'b0;
      idle(3);
      check_eq("rst_busy", bus.busy, 1'b0);
      check_eq("rst_pulses", bus.step_divisor | bus.meas_valid | bus.done, 1'b0);
      check_eq("rst_step_index", bus.step_index, 8'd0);
      check_eq("rst_meas_count", bus.meas_count, 16'd0);
      check_eq("rst_sat_meas", sat_bus.meas_count, 4'd0);
      nreset = 1'b1;
      idle(4);

      run_sweep(3, 10, 1'b0, 0, 0);                  // basic timing
      div_period = 4; div_phase = $urandom_range(0, 3);
      idle(6);
      run_sweep(2, 20, 1'b0, 0, 0);                  // measurement, 5 edges per dwell
      run_sweep(2, 5, 1'b1, 2 * 2 * 6 + 1 + $urandom_range(0, 4), 0);
      start_ignored(0, 10, 1'b0);
      start_ignored(3, 0, 1'b0);
      start_ignored(3, 10, 1'b1);
      run_sweep(2, 6, 1'b0, 0, 7);                   // second start while busy

      // Saturation on the narrow-count instance.
      div_period = 2; div_phase = 0;
      idle(6);
      @(negedge clock_in);
      sat_bus.cfg_steps = 8'd1; sat_bus.cfg_dwell = 16'd100; sat_bus.start = 1'b1;
      base = cyc; hit = 0;
      for (int n = 1; n <= 120; n++) begin
         @(negedge clock_in);
         sat_bus.start = 1'b0;
         if (sat_bus.meas_valid) begin hit = n; break; end
      end
      cnt = rises(base + 1, base + 100);
      check_eq("sat_cycle", hit, 101);
      check_eq("sat_meas_count", sat_bus.meas_count, (cnt > 15) ? 15 : cnt);
      idle(4);

      // Asynchronous reset while the step pulse is high.
      @(negedge clock_in);
      bus.cfg_steps = 8'd3; bus.cfg_dwell = 16'd4; bus.cfg_continuous = 1'b0; bus.start = 1'b1;
      hit = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clock_in);
         bus.start = 1'b0;
         if (bus.step_divisor) begin hit = n; break; end
      end
      check_eq("rst_mid_step_cycle", hit, 5);
      nreset = 1'b0;
      #1;
      check_eq("arst_busy", bus.busy, 1'b0);
      check_eq("arst_pulses", bus.step_divisor | bus.meas_valid | bus.done, 1'b0);
      check_eq("arst_step_index", bus.step_index, 8'd0);
      check_eq("arst_meas_count", bus.meas_count, 16'd0);
      @(negedge clock_in);
      nreset = 1'b1;
      exp_meas = 16'd0;
      idle(4);
      run_sweep(2, 3, 1'b0, 0, 0);

      // Randomised sweeps.
      for (int it = 0; it < 8; it++) begin
         div_period = periods[$urandom_range(0, 5)];
         div_phase  = $urandom_range(0, 7);
         idle(5);
         ns = $urandom_range(1, 4);
         d  = $urandom_range(1, 12);
         cont = 1'($urandom_range(0, 1));
         ab = 0; rs = 0;
         if (cont)
            ab = $urandom_range(1, ns + 1) * (d + 1) + 1 + $urandom_range(0, d - 1);
         else if ($urandom_range(0, 1) == 1)
            ab = $urandom_range(0, ns - 1) * (d + 1) + 1 + $urandom_range(0, d - 1);
         else if ($urandom_range(0, 1) == 1)
            rs = $urandom_range(1, ns * (d + 1));
         run_sweep(ns, d, cont, ab, rs);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
